ball_step_engine: RTL and testbench

Tick-driven ball position engine for the brick-breaker datapath. Consumes the one-cycle timing pulse produced by the game's delay/tick counter and, per tick, runs an erase-move-draw sequence against the pixel plotter through a req/ack handshake. It reflects the ball off the four screen edges and holds the authoritative ball position and direction for collision and scoring logic.

---
 rtl/ball_pkg.sv | 13 +
 rtl/ball_axis_step.sv | 23 ++
 rtl/ball_step_engine.sv | 116 +++++++++++
 tb/tb_ball_step_engine.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ball_pkg.sv
// ball_pkg: shared state encoding and default screen geometry for the ball stepper.
package ball_pkg;

    typedef enum logic [1:0] {IDLE, ERASE, MOVE, DRAW} ball_state_t;

    localparam int X_W_DEF    = 8;
    localparam int Y_W_DEF    = 7;
    localparam int X_MAX_DEF  = 159;
    localparam int Y_MAX_DEF  = 119;
    localparam int X_INIT_DEF = 80;
    localparam int Y_INIT_DEF = 60;

endpackage

// File: rtl/ball_axis_step.sv
// ball_axis_step: one-axis position step that reflects off 0 and MAX without wrapping.
module ball_axis_step #(
    parameter int W   = 8,
    parameter int MAX = 159
) (
    input  logic [W-1:0] pos,
    input  logic         neg,
    output logic [W-1:0] next_pos,
    output logic         next_neg
);

    localparam logic [W-1:0] ONE    = W'(1);
    localparam logic [W-1:0] MAX_V  = W'(MAX);
    localparam logic [W-1:0] MAX_M1 = W'(MAX - 1);

    logic at_lo, at_hi;

    assign at_lo    = (pos == '0);
    assign at_hi    = (pos == MAX_V);
    assign next_pos = neg ? (at_lo ? ONE : pos - ONE) : (at_hi ? MAX_M1 : pos + ONE);
    assign next_neg = neg ? !at_lo : at_hi;

endmodule

// File: rtl/ball_step_engine.sv
// ball_step_engine: per-tick erase/move/draw ball stepper with a req/ack plotter handshake.
// Optional BALL_STEP_PAUSE_EN adds a pause input that suppresses ticks while idle.
module ball_step_engine
    import ball_pkg::*;
#(
    parameter int X_W    = X_W_DEF,
    parameter int Y_W    = Y_W_DEF,
    parameter int X_MAX  = X_MAX_DEF,
    parameter int Y_MAX  = Y_MAX_DEF,
    parameter int X_INIT = X_INIT_DEF,
    parameter int Y_INIT = Y_INIT_DEF
) (
    input  logic           clock,
    input  logic           resetn,
    input  logic           tick,
    input  logic           draw_ack,
`ifdef BALL_STEP_PAUSE_EN
    input  logic           pause,
`endif
    output logic           draw_req,
    output logic           erase,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           dx_neg,
    output logic           dy_neg,
    output logic           busy,
    output logic           overrun
);

    ball_state_t    state_q;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
    logic           pending_q, overrun_q, draw_req_q, erase_q, busy_q;
    logic           hold;

`ifdef BALL_STEP_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    ball_axis_step #(.W(X_W), .MAX(X_MAX)) u_x_step (
        .pos(x_q), .neg(dx_neg_q), .next_pos(x_d), .next_neg(dx_neg_d)
    );

    ball_axis_step #(.W(Y_W), .MAX(Y_MAX)) u_y_step (
        .pos(y_q), .neg(dy_neg_q), .next_pos(y_d), .next_neg(dy_neg_d)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            x_q        <= X_W'(X_INIT);
            y_q        <= Y_W'(Y_INIT);
            dx_neg_q   <= 1'b0;
            dy_neg_q   <= 1'b1;
            pending_q  <= 1'b0;
            overrun_q  <= 1'b0;
            draw_req_q <= 1'b0;
            erase_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hold) begin
                        pending_q <= 1'b0;
                    end else if (tick || pending_q) begin
                        state_q    <= ERASE;
                        pending_q  <= 1'b0;
                        draw_req_q <= 1'b1;
                        erase_q    <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ERASE: begin
                    if (draw_ack) begin
                        state_q    <= MOVE;
                        draw_req_q <= 1'b0;
                    end
                end
                MOVE: begin
                    state_q    <= DRAW;
                    x_q        <= x_d;
                    y_q        <= y_d;
                    dx_neg_q   <= dx_neg_d;
                    dy_neg_q   <= dy_neg_d;
                    draw_req_q <= 1'b1;
                    erase_q    <= 1'b0;
                end
                DRAW: begin
                    if (draw_ack) begin
                        state_q    <= IDLE;
                        draw_req_q <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
            endcase
            // one-deep tick buffer while a step is in flight
            if (state_q != IDLE && tick) begin
                pending_q <= 1'b1;
                if (pending_q) overrun_q <= 1'b1;
            end
        end
    end

    assign draw_req = draw_req_q;
    assign erase    = erase_q;
    assign x        = x_q;
    assign y        = y_q;
    assign dx_neg   = dx_neg_q;
    assign dy_neg   = dy_neg_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_ball_step_engine.sv
// tb_ball_step_engine: directed self-checking bench for ball_step_engine.
module tb_ball_step_engine;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic       draw_ack = 1'b0;
    logic       pause = 1'b0;
    logic       draw_req, erase, dx_neg, dy_neg, busy, overrun;
    logic [7:0] x;
    logic [6:0] y;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    ball_step_engine dut (
        .clock(clock), .resetn(resetn), .tick(tick), .draw_ack(draw_ack),
`ifdef BALL_STEP_PAUSE_EN
        .pause(pause),
`endif
        .draw_req(draw_req), .erase(erase), .x(x), .y(y),
        .dx_neg(dx_neg), .dy_neg(dy_neg), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic serve();
        int n = 0;
        while (!draw_req && n < 20) begin
            cyc();
            n++;
        end
        chk("req_timeout", 32'(n < 20), 1);
        draw_ack = 1'b1;
        cyc();
        draw_ack = 1'b0;
    endtask

    task automatic step_auto();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        serve();
        serve();
    endtask

    initial begin
        cyc();
        cyc();
        chk("rst_req", draw_req, 0);
        chk("rst_erase", erase, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", overrun, 0);
        chk("rst_x", x, 80);
        chk("rst_y", y, 60);
        chk("rst_dx", dx_neg, 0);
        chk("rst_dy", dy_neg, 1);
        resetn = 1'b1;
        cyc();
        // first step, immediate acks
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("s1_c1_req", draw_req, 1);
        chk("s1_c1_erase", erase, 1);
        chk("s1_c1_x", x, 80);
        chk("s1_c1_y", y, 60);
        chk("s1_c1_busy", busy, 1);
        draw_ack = 1'b1;
        cyc();
        draw_ack = 1'b0;
        chk("s1_c2_req", draw_req, 0);
        chk("s1_c2_busy", busy, 1);
        cyc();
        chk("s1_c3_req", draw_req, 1);
        chk("s1_c3_erase", erase, 0);
        chk("s1_c3_x", x, 81);
        chk("s1_c3_y", y, 59);
        draw_ack = 1'b1;
        cyc();
        draw_ack = 1'b0;
        chk("s1_c4_busy", busy, 0);
        chk("s1_c4_req", draw_req, 0);
        chk("s1_dx", dx_neg, 0);
        chk("s1_dy", dy_neg, 1);
        // ack stall in ERASE
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", draw_req, 1);
            chk("stall_erase", erase, 1);
            chk("stall_x", x, 81);
            chk("stall_y", y, 59);
            cyc();
        end
        chk("stall_req_end", draw_req, 1);
        draw_ack = 1'b1;
        cyc();
        draw_ack = 1'b0;
        chk("stall_move_req", draw_req, 0);
        cyc();
        chk("stall_draw_req", draw_req, 1);
        chk("stall_draw_x", x, 82);
        chk("stall_draw_y", y, 58);
        draw_ack = 1'b1;
        cyc();
        draw_ack = 1'b0;
        chk("stall_idle", busy, 0);
        // two ticks during one step
        tick = 1'b1;
        cyc();
        cyc();
        chk("ovr_pre", overrun, 0);
        cyc();
        tick = 1'b0;
        chk("ovr_set", overrun, 1);
        serve();
        serve();
        chk("ovr_idle_gap", busy, 0);
        cyc();
        chk("ovr_extra_req", draw_req, 1);
        chk("ovr_extra_x", x, 83);
        serve();
        serve();
        for (int i = 0; i < 6; i++) begin
            chk("ovr_no_more", draw_req, 0);
            cyc();
        end
        chk("ovr_pos_x", x, 84);
        chk("ovr_pos_y", y, 56);
        chk("ovr_sticky", overrun, 1);
        // ack outside ERASE/DRAW ignored
        draw_ack = 1'b1;
        cyc();
        cyc();
        draw_ack = 1'b0;
        chk("stray_ack_busy", busy, 0);
        chk("stray_ack_x", x, 84);
        // tick coincident with final DRAW ack
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        serve();
        while (!draw_req) cyc();
        draw_ack = 1'b1;
        tick = 1'b1;
        cyc();
        draw_ack = 1'b0;
        tick = 1'b0;
        chk("coin_idle_busy", busy, 0);
        chk("coin_idle_req", draw_req, 0);
        cyc();
        chk("coin_restart_req", draw_req, 1);
        chk("coin_restart_erase", erase, 1);
        chk("coin_restart_x", x, 85);
        chk("coin_restart_y", y, 55);
        serve();
        serve();
        // async reset while DRAW pending
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        serve();
        while (!draw_req) cyc();
        chk("arst_pre_req", draw_req, 1);
        resetn = 1'b0;
        #1;
        chk("arst_req", draw_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_x", x, 80);
        chk("arst_y", y, 60);
        chk("arst_ovr", overrun, 0);
        cyc();
        resetn = 1'b1;
        cyc();
        // edge reflection sweep from (80,60)
        for (int i = 1; i <= 80; i++) begin
            step_auto();
            if (i == 60) begin
                chk("sw60_y", y, 0);
                chk("sw60_dy", dy_neg, 1);
                chk("sw60_x", x, 140);
            end
            if (i == 61) begin
                chk("sw61_y", y, 1);
                chk("sw61_dy", dy_neg, 0);
            end
            if (i == 79) begin
                chk("sw79_x", x, 159);
                chk("sw79_dx", dx_neg, 0);
            end
        end
        chk("sw80_x", x, 158);
        chk("sw80_dx", dx_neg, 1);
        chk("sw80_y", y, 20);
        chk("sw_ovr", overrun, 0);
`ifdef BALL_STEP_PAUSE_EN
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            chk("pause_req", draw_req, 0);
            cyc();
            chk("pause_busy", busy, 0);
        end
        chk("pause_x", x, 158);
        chk("pause_y", y, 20);
        chk("pause_ovr", overrun, 0);
        pause = 1'b0;
        cyc();
        chk("unpause_idle", busy, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
